// File: rtl/checkout_pkg.sv
// ---------------------------------------------------------------------------
// checkout_pkg
//
// Shared types and constants for the checkout tally stage.
//   tally_state_t : controller state (IDLE / ALARM)
//   UPC_W         : width of the UPC code carried from the scanner switches
// ---------------------------------------------------------------------------
package checkout_pkg;

    localparam int UPC_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        ALARM = 1'b1
    } tally_state_t;

endpackage : checkout_pkg

// File: rtl/checkout_tally_key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//
// Conditions one raw, active-low push-button for use in the clk domain:
// a 2-flop synchronizer followed by a stability filter. The filtered level
// only follows the synchronized level after it has differed from the current
// filtered level for DEBOUNCE_CYCLES consecutive cycles; any bounce back
// restarts the count.
//
// Ports
//   clk           : system clock
//   reset_n       : asynchronous active-low reset
//   key_n         : raw button level, active-low, asynchronous to clk
//   pressed_pulse : one-cycle strobe when the filtered level goes 1 -> 0
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic pressed_pulse
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             filt_q,  filt_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pulse_q, pulse_d;

    // NOTE: the synchronizer resets to the pressed level (0). A button held
    // through reset then never looks released, so it cannot arm the filter
    // until it is genuinely let go.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both stages sample their
            // inputs from before the edge; blocking here would collapse the
            // two-flop chain into one.
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // Until armed, the counter measures how long the key has been seen
    // released; only a full stable release arms press detection. Once armed
    // it measures how long the synchronized level has disagreed with the
    // filtered level.
    always_comb begin
        // NOTE: every variable gets its default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        filt_d  = filt_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;

        if (!armed_q) begin
            if (!sync2_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                armed_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (sync2_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            filt_d  = sync2_q;
            cnt_d   = '0;
            pulse_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q  <= 1'b1;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            filt_q  <= filt_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pressed_pulse = pulse_q;

endmodule : key_debounce

// File: rtl/checkout_tally.sv
// ---------------------------------------------------------------------------
// checkout_tally
//
// Tally stage for the checkout station. Debounced scan-key presses count
// items (and discounted items) into saturating counters; a stolen item
// latches an alarm holding its UPC until an operator presses clear.
//
// Ports
//   clk, reset_n   : system clock, asynchronous active-low reset
//   scan_key_n     : raw scan button, active-low, asynchronous
//   clear_key_n    : raw alarm-clear button, active-low, asynchronous
//   upc            : UPC code of the item at the scanner
//   discount       : discount flag for the current upc
//   stolen         : stolen flag for the current upc / marked bit
//   item_count     : items accepted since reset (saturating)
//   discount_count : accepted items with discount set (saturating)
//   alarm          : stolen alarm latched (state == ALARM)
//   alarm_upc      : UPC that raised the alarm, 0 when no alarm
//   scan_pulse     : one-cycle strobe per accepted scan
// ---------------------------------------------------------------------------
module checkout_tally
    import checkout_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               scan_key_n,
    input  logic               clear_key_n,
    input  logic [UPC_W-1:0]   upc,
    input  logic               discount,
    input  logic               stolen,
    output logic [COUNT_W-1:0] item_count,
    output logic [COUNT_W-1:0] discount_count,
    output logic               alarm,
    output logic [UPC_W-1:0]   alarm_upc,
    output logic               scan_pulse
);

    logic scan_ev;
    logic clear_ev;

    tally_state_t       state_q,      state_d;
    logic               alarm_q,      alarm_d;
    logic [COUNT_W-1:0] item_q,       item_d;
    logic [COUNT_W-1:0] disc_q,       disc_d;
    logic [UPC_W-1:0]   alarm_upc_q,  alarm_upc_d;
    logic               scan_pulse_q, scan_pulse_d;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_scan_db (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_n         (scan_key_n),
        .pressed_pulse (scan_ev)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clear_db (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_n         (clear_key_n),
        .pressed_pulse (clear_ev)
    );

    // Holds at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The state decides which key wins when both fire together: IDLE only
    // listens to scan, ALARM only listens to clear.
    always_comb begin
        state_d      = state_q;
        item_d       = item_q;
        disc_d       = disc_q;
        alarm_upc_d  = alarm_upc_q;
        scan_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (scan_ev) begin
                    scan_pulse_d = 1'b1;
                    item_d       = sat_inc(item_q);
                    if (discount) begin
                        disc_d = sat_inc(disc_q);
                    end
                    if (stolen) begin
                        alarm_upc_d = upc;
                        state_d     = ALARM;
                    end
                end
            end
            ALARM: begin
                if (clear_ev) begin
                    alarm_upc_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                alarm_upc_d = '0;
                state_d     = IDLE;
            end
        endcase

        alarm_d = (state_d == ALARM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            alarm_q      <= 1'b0;
            item_q       <= '0;
            disc_q       <= '0;
            alarm_upc_q  <= '0;
            scan_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_q      <= alarm_d;
            item_q       <= item_d;
            disc_q       <= disc_d;
            alarm_upc_q  <= alarm_upc_d;
            scan_pulse_q <= scan_pulse_d;
        end
    end

    assign item_count     = item_q;
    assign discount_count = disc_q;
    assign alarm          = alarm_q;
    assign alarm_upc      = alarm_upc_q;
    assign scan_pulse     = scan_pulse_q;

endmodule : checkout_tally

// File: tb/tb_checkout_tally.sv
// ---------------------------------------------------------------------------
// tb_checkout_tally
//
// Directed bench for checkout_tally with DEBOUNCE_CYCLES=4, COUNT_W=4.
// Expected outputs come from a small event-level model: a clean press that
// falls just after edge e is accepted at edge e+7, where the model applies
// the scan/clear rule table. A compare process checks every output at every
// falling edge; literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_checkout_tally;

    localparam int DB   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          scan_key_n;
    logic          clear_key_n;
    logic [2:0]    upc;
    logic          discount;
    logic          stolen;
    logic [CW-1:0] item_count;
    logic [CW-1:0] discount_count;
    logic          alarm;
    logic [2:0]    alarm_upc;
    logic          scan_pulse;

    checkout_tally #(
        .DEBOUNCE_CYCLES (DB),
        .COUNT_W         (CW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .scan_key_n     (scan_key_n),
        .clear_key_n    (clear_key_n),
        .upc            (upc),
        .discount       (discount),
        .stolen         (stolen),
        .item_count     (item_count),
        .discount_count (discount_count),
        .alarm          (alarm),
        .alarm_upc      (alarm_upc),
        .scan_pulse     (scan_pulse)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model of the outputs.
    int       exp_item  = 0;
    int       exp_disc  = 0;
    bit       exp_alarm = 1'b0;
    bit [2:0] exp_upc   = 3'd0;
    bit       exp_pulse = 1'b0;

    int pulses_seen    = 0;
    int last_pulse_cyc = -1;
    int last_fall_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Rule table applied at the edge where an accepted key event lands.
    task automatic model_event(input bit s, input bit c);
        if (!exp_alarm) begin
            if (s) begin
                exp_item  = sat(exp_item + 1);
                if (discount) exp_disc = sat(exp_disc + 1);
                exp_pulse = 1'b1;
                if (stolen) begin
                    exp_alarm = 1'b1;
                    exp_upc   = upc;
                end
            end
        end else if (c) begin
            exp_alarm = 1'b0;
            exp_upc   = 3'd0;
        end
    endtask

    task automatic model_reset();
        exp_item  = 0;
        exp_disc  = 0;
        exp_alarm = 1'b0;
        exp_upc   = 3'd0;
        exp_pulse = 1'b0;
    endtask

    always @(negedge clk) begin
        check("item_count",     32'(item_count),     32'(exp_item));
        check("discount_count", 32'(discount_count), 32'(exp_disc));
        check("alarm",          32'(alarm),          32'(exp_alarm));
        check("alarm_upc",      32'(alarm_upc),      32'(exp_upc));
        check("scan_pulse",     32'(scan_pulse),     32'(exp_pulse));
        if (scan_pulse === 1'b1) begin
            pulses_seen++;
            last_pulse_cyc = cyc;
        end
    end

    // Clean press of the selected key(s) held for `hold` cycles, then a
    // release long enough for the filter to return to released.
    task automatic press(input bit s, input bit c, input int hold);
        @(posedge clk);
        #1;
        last_fall_cyc = cyc;
        if (s) scan_key_n  = 1'b0;
        if (c) clear_key_n = 1'b0;
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk);
            if (i == 7) model_event(s, c);
            if (i == 8) exp_pulse = 1'b0;
        end
        #1;
        scan_key_n  = 1'b1;
        clear_key_n = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    int base_pulses;

    initial begin
        reset_n     = 1'b0;
        scan_key_n  = 1'b1;
        clear_key_n = 1'b1;
        upc         = 3'd0;
        discount    = 1'b0;
        stolen      = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);

        // Clean scan.
        #1;
        upc = 3'b010; discount = 1'b1; stolen = 1'b0;
        press(1'b1, 1'b0, 10);
        check("clean_item_lit",   32'(item_count),     32'd1);
        check("clean_disc_lit",   32'(discount_count), 32'd1);
        check("clean_pulse_lat",  32'(last_pulse_cyc - last_fall_cyc), 32'd7);
        check("clean_pulse_cnt",  32'(pulses_seen),    32'd1);

        // Bounce: 2-cycle segments never reach the debounce length.
        base_pulses = pulses_seen;
        discount = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            #1 scan_key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(posedge clk);
        end
        #1 scan_key_n = 1'b1;
        repeat (10) @(posedge clk);
        check("bounce_no_pulse", 32'(pulses_seen - base_pulses), 32'd0);
        press(1'b1, 1'b0, 10);
        check("bounce_then_item", 32'(item_count),     32'd2);
        check("bounce_then_disc", 32'(discount_count), 32'd1);

        // Alarm raise, ignored scans, clear.
        upc = 3'b101; stolen = 1'b1;
        press(1'b1, 1'b0, 10);
        check("alarm_lit",     32'(alarm),      32'd1);
        check("alarm_upc_lit", 32'(alarm_upc),  32'd5);
        check("alarm_item",    32'(item_count), 32'd3);
        base_pulses = pulses_seen;
        stolen = 1'b0; upc = 3'b001; discount = 1'b1;
        repeat (3) press(1'b1, 1'b0, 10);
        check("alarm_ignored_pulses", 32'(pulses_seen - base_pulses), 32'd0);
        check("alarm_ignored_item",   32'(item_count), 32'd3);
        press(1'b0, 1'b1, 10);
        check("clear_alarm",     32'(alarm),          32'd0);
        check("clear_upc",       32'(alarm_upc),      32'd0);
        check("clear_keep_item", 32'(item_count),     32'd3);
        check("clear_keep_disc", 32'(discount_count), 32'd1);

        // Clear in IDLE does nothing.
        press(1'b0, 1'b1, 10);
        check("idle_clear_item", 32'(item_count), 32'd3);

        // Simultaneous events.
        upc = 3'b110; discount = 1'b1; stolen = 1'b1;
        press(1'b1, 1'b1, 10);
        check("sim_idle_alarm", 32'(alarm),          32'd1);
        check("sim_idle_upc",   32'(alarm_upc),      32'd6);
        check("sim_idle_item",  32'(item_count),     32'd4);
        check("sim_idle_disc",  32'(discount_count), 32'd2);
        press(1'b1, 1'b1, 10);
        check("sim_alarm_clr",  32'(alarm),      32'd0);
        check("sim_alarm_item", 32'(item_count), 32'd4);

        // Reset during ALARM with the scan key mid-debounce and held past
        // reset release: no event may follow until a fresh press.
        upc = 3'b011; stolen = 1'b1; discount = 1'b0;
        press(1'b1, 1'b0, 10);
        stolen = 1'b0;
        @(posedge clk);
        #1 scan_key_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_item",  32'(item_count),     32'd0);
        check("rst_async_disc",  32'(discount_count), 32'd0);
        check("rst_async_alarm", 32'(alarm),          32'd0);
        check("rst_async_upc",   32'(alarm_upc),      32'd0);
        check("rst_async_pulse", 32'(scan_pulse),     32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        base_pulses = pulses_seen;
        repeat (15) @(posedge clk);
        #1 scan_key_n = 1'b1;
        repeat (12) @(posedge clk);
        check("held_no_event", 32'(pulses_seen - base_pulses), 32'd0);
        press(1'b1, 1'b0, 10);
        check("after_rst_item", 32'(item_count),     32'd1);
        check("after_rst_disc", 32'(discount_count), 32'd0);

        // Saturation.
        discount = 1'b1;
        base_pulses = pulses_seen;
        repeat (17) press(1'b1, 1'b0, 10);
        check("sat_item",   32'(item_count),     32'd15);
        check("sat_disc",   32'(discount_count), 32'd15);
        check("sat_pulses", 32'(pulses_seen - base_pulses), 32'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_checkout_tally

// File: doc/checkout_tally.md
# checkout_tally

Downstream tally stage for the checkout station. It consumes the per-item UPC code, the marked bit, and the combinational discount/stolen flags. On each debounced scan-key press it counts scanned and discounted items. A stolen item latches an alarm that records its UPC until an operator clear. Its outputs drive the LEDR alarm lamp and the HEX count display in the board top level.

## Interface
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required before a key level change is accepted (≥1).
- COUNT_W, default 8: width of each tally counter.
- clk  input  1  system clock (CLOCK_50 at board level).
- reset_n  input  1  asynchronous, active-low reset.
- scan_key_n  input  1  raw scan push-button, active-low (KEY[0]), asynchronous to clk.
- clear_key_n  input  1  raw alarm-clear push-button, active-low (KEY[1]), asynchronous.
- upc  input  3  UPC code of the item at the scanner (SW[9:7]).
- discount  input  1  discount flag for the current upc.
- stolen  input  1  stolen flag for the current upc and marked bit.
- item_count  output  COUNT_W  items accepted since reset.
- discount_count  output  COUNT_W  accepted items whose discount flag was set.
- alarm  output  1  stolen alarm latched.
- alarm_upc  output  3  UPC that raised the alarm; 0 when no alarm.
- scan_pulse  output  1  one-cycle strobe for each accepted scan.

## Operation
- Both keys pass through a 2-flop synchronizer and then a debouncer. A key event is the filtered level going from released (1) to pressed (0). Release and repress produce a new event; holding the key produces exactly one event.
- Each sampled scan uses the upc/discount/stolen values present in the event cycle.
- Reset forces all outputs to 0, sets filtered key levels to released (1), clears debounce counters, and sets the state to IDLE.
- State IDLE:
  - Scan event with stolen=0: item_count+1; discount_count+1 if discount=1; scan_pulse=1; stay in IDLE.
  - Scan event with stolen=1: item_count+1; discount_count+1 if discount=1; scan_pulse=1; alarm_upc←upc; go to ALARM.
  - Clear event: no effect.
- State ALARM:
  - alarm=1.
  - Scan events are ignored: no count change, no scan_pulse.
  - Clear event: alarm_upc←0, go to IDLE. Counters are kept.
- Simultaneous scan and clear events in the same cycle:
  - In IDLE, the scan is processed and the clear is ignored.
  - In ALARM, the clear is processed and the scan is ignored.
- Counters saturate at 2^COUNT_W−1; a saturated counter holds its value and scan_pulse still fires.
- An async reset during ALARM or during a debounce in progress fully clears the block. A key still held when reset is released must be released and re-pressed before it generates an event.

## Timing
- Raw key low from edge k, stable → synchronized low at edge k+2 → filtered level low at edge k+2+DEBOUNCE_CYCLES.
- The event strobe and scan_pulse are high during the following cycle. Counters, alarm and alarm_upc update at the edge ending that cycle.
- Glitches shorter than DEBOUNCE_CYCLES restart the stability count and produce no event.
- All outputs are registered; there is no combinational path from any input to any output.
- alarm equals (state==ALARM) and is registered together with the state.

## Structure
- checkout_pkg holds:
  - the state enum tally_state_t {IDLE, ALARM};
  - localparam UPC_W=3.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES), instantiated twice. Ports:
  - clk, reset_n, key_n (raw);
  - pressed_pulse (one-cycle strobe on the filtered 1→0 transition).
- Debounce counter width is $clog2(DEBOUNCE_CYCLES+1).
- The top-level body contains the FSM, the saturating counters and the alarm_upc register.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and COUNT_W=4.
- Reset: assert reset_n=0 mid-run → all outputs 0 immediately and held until release.
- Clean scan: hold scan_key_n low 10 cycles with upc=3'b010, discount=1, stolen=0 → scan_pulse exactly once, 7 cycles after the fall; item_count=1, discount_count=1.
- Bounce: toggle scan_key_n every 2 cycles for 20 cycles, then release → no scan_pulse and counts unchanged. A following clean 10-cycle press → one event.
- Alarm: scan with upc=3'b101, stolen=1 → item_count+1, alarm=1, alarm_upc=3'b101. Three further scans → no change. A clear press → alarm=0, alarm_upc=0, counts retained.
- Saturation: 17 clean scans with discount=1 → item_count=15 and discount_count=15; scan_pulse seen 17 times.
- Simultaneous events:
  - In IDLE, press both keys on the same cycle with stolen=1 → alarm set, clear ignored.
  - Repeat in ALARM → alarm cleared, scan not counted.
